// File: rtl/img_sel_ctrl_if.sv
// Button/frame inputs and index/mode outputs of the image selection controller.
// The controller connects through the slave modport; its driver uses master.
interface img_sel_ctrl_if #(
  parameter int unsigned IDX_W = 2
);
  logic             btn_next;
  logic             btn_prev;
  logic             btn_mode;
  logic             frame_start;
  logic [IDX_W-1:0] img_idx;
  logic [IDX_W-1:0] target_idx;
  logic             pending;
  logic             idx_changed;
  logic [1:0]       mode;

  modport master (
    output btn_next, btn_prev, btn_mode, frame_start,
    input  img_idx, target_idx, pending, idx_changed, mode
  );

  modport slave (
    input  btn_next, btn_prev, btn_mode, frame_start,
    output img_idx, target_idx, pending, idx_changed, mode
  );
endinterface

// File: rtl/img_sel_ctrl.sv
// Turns debounced next/prev/mode pulses into an image index that commits only
// on frame_start, with an optional slideshow timer that auto-advances the index.
module img_sel_ctrl #(
  parameter int unsigned NUM_IMG     = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned SLIDE_TICKS = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic            clk,
  input  logic            clr,
  img_sel_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_RUN  = 2'b01,
    AUTO_HOLD = 2'b10,
    MODE_BAD  = 2'b11
  } mode_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLIDE_TICKS - 1);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] target_q, target_d;
  logic [IDX_W-1:0] img_q, img_d;
  logic             pending_q, pending_d;
  logic             changed_q, changed_d;

  logic man_fwd;
  logic man_back;
  logic manual;
  logic auto_adv;

  // Simultaneous next+prev cancels; a manual step pre-empts the slideshow tick.
  assign man_fwd  = bus.btn_next & ~bus.btn_prev;
  assign man_back = bus.btn_prev & ~bus.btn_next;
  assign manual   = man_fwd | man_back;
  assign auto_adv = (mode_q == AUTO_RUN) && (cnt_q == LAST_CNT) && !manual;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mode_q    <= MANUAL;
      cnt_q     <= '0;
      target_q  <= '0;
      img_q     <= '0;
      pending_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      img_q     <= img_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    cnt_d     = '0;
    target_d  = target_q;
    img_d     = img_q;
    pending_d = pending_q;
    changed_d = 1'b0;

    unique case (mode_q)
      MANUAL:    if (bus.btn_mode) mode_d = AUTO_RUN;
      AUTO_RUN:  if (bus.btn_mode) mode_d = AUTO_HOLD;
      AUTO_HOLD: if (bus.btn_mode) mode_d = MANUAL;
      default:   mode_d = MANUAL;
    endcase

    // Timer runs only while staying in AUTO_RUN; entry, exit and manual steps restart it.
    if ((mode_q == AUTO_RUN) && (mode_d == AUTO_RUN) && !manual && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (man_fwd || auto_adv) begin
      target_d = (target_q == LAST_IDX) ? '0 : target_q + IDX_W'(1);
    end else if (man_back) begin
      target_d = (target_q == '0) ? LAST_IDX : target_q - IDX_W'(1);
    end

    // Commit uses the pre-step target; a same-cycle step waits for the next frame.
    if (bus.frame_start) begin
      img_d     = target_q;
      changed_d = (target_q != img_q);
    end

    pending_d = (target_d != img_d);
  end

  assign bus.img_idx     = img_q;
  assign bus.target_idx  = target_q;
  assign bus.pending     = pending_q;
  assign bus.idx_changed = changed_q;
  assign bus.mode        = mode_q;

endmodule

// File: tb/tb_img_sel_ctrl.sv
// Bench for img_sel_ctrl: directed vector table, timer/commit/reset sequences,
// and randomized pulses checked against an arithmetic reference model.
module tb_img_sel_ctrl;

  localparam int unsigned NUM_IMG     = 3;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned SLIDE_TICKS = 10;
  localparam int unsigned CNT_W       = 4;

  logic clk;
  logic clr;

  img_sel_ctrl_if #(.IDX_W(IDX_W)) bus ();

  img_sel_ctrl #(
    .NUM_IMG    (NUM_IMG),
    .IDX_W      (IDX_W),
    .SLIDE_TICKS(SLIDE_TICKS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_target, m_img, m_mode, m_cnt, m_pend, m_chg;

  typedef struct {
    bit    n, p, m, f;
    int    tgt, img, pend, chg, mode;
    string name;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_target = 0; m_img = 0; m_mode = 0; m_cnt = 0; m_pend = 0; m_chg = 0;
  endtask

  task automatic model_step(input bit n, input bit p, input bit m, input bit f);
    int  nt, nmode, ncnt;
    bit  manual, auto_adv;
    manual   = n ^ p;
    auto_adv = (m_mode == 1) && (m_cnt == SLIDE_TICKS - 1) && !manual;
    nt = m_target;
    if ((n && !p) || auto_adv) nt = (m_target + 1) % NUM_IMG;
    else if (p && !n)          nt = (m_target + NUM_IMG - 1) % NUM_IMG;
    nmode = m ? (m_mode + 1) % 3 : m_mode;
    ncnt  = (m_mode == 1 && nmode == 1 && !manual) ? (m_cnt + 1) % SLIDE_TICKS : 0;
    m_chg = (f && (m_target != m_img)) ? 1 : 0;
    if (f) m_img = m_target;
    m_target = nt;
    m_mode   = nmode;
    m_cnt    = ncnt;
    m_pend   = (m_target != m_img) ? 1 : 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".target"},  int'(bus.target_idx),  m_target);
    chk({tag, ".img"},     int'(bus.img_idx),     m_img);
    chk({tag, ".pending"}, int'(bus.pending),     m_pend);
    chk({tag, ".changed"}, int'(bus.idx_changed), m_chg);
    chk({tag, ".mode"},    int'(bus.mode),        m_mode);
  endtask

  // One clock: drive pulses, let the edge sample them, then compare against the model.
  task automatic drive(input bit n, input bit p, input bit m, input bit f, input string tag);
    bus.btn_next    = n;
    bus.btn_prev    = p;
    bus.btn_mode    = m;
    bus.frame_start = f;
    @(posedge clk);
    model_step(n, p, m, f);
    #1;
    bus.btn_next    = 1'b0;
    bus.btn_prev    = 1'b0;
    bus.btn_mode    = 1'b0;
    bus.frame_start = 1'b0;
    check_model(tag);
  endtask

  vec_t vecs[$];

  initial begin
    clr             = 1'b0;
    bus.btn_next    = 1'b0;
    bus.btn_prev    = 1'b0;
    bus.btn_mode    = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();

    //            n  p  m  f  tgt img pend chg mode
    vecs.push_back('{1, 0, 0, 0, 1, 0, 1, 0, 0, "next1"});
    vecs.push_back('{1, 0, 0, 0, 2, 0, 1, 0, 0, "next2"});
    vecs.push_back('{0, 0, 0, 1, 2, 2, 0, 1, 0, "commit2"});
    vecs.push_back('{0, 0, 0, 0, 2, 2, 0, 0, 0, "pulse_end"});
    vecs.push_back('{1, 0, 0, 0, 0, 2, 1, 0, 0, "wrap_up"});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, "commit0"});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, "idle0"});
    vecs.push_back('{0, 1, 0, 0, 2, 0, 1, 0, 0, "wrap_down"});
    vecs.push_back('{0, 0, 0, 1, 2, 2, 0, 1, 0, "commit_wd"});
    vecs.push_back('{1, 0, 0, 0, 0, 2, 1, 0, 0, "wrap_up2"});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, "commit_wu"});
    vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 0, "both"});
    vecs.push_back('{1, 1, 0, 1, 0, 0, 0, 0, 0, "both_frame"});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 1, 0, 0, "fwd_then"});
    vecs.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, "back_equal"});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, "frame_nochg"});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 1, 0, 0, "step_at_frame"});
    vecs.push_back('{0, 0, 0, 1, 1, 1, 0, 1, 0, "late_commit"});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 0, 0, 0, "idle1"});
    vecs.push_back('{0, 1, 0, 0, 0, 1, 1, 0, 0, "back_to0"});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, "commit_back"});

    // Reset state
    #2;
    chk("rst.target",  int'(bus.target_idx),  0);
    chk("rst.img",     int'(bus.img_idx),     0);
    chk("rst.pending", int'(bus.pending),     0);
    chk("rst.changed", int'(bus.idx_changed), 0);
    chk("rst.mode",    int'(bus.mode),        0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].n, vecs[i].p, vecs[i].m, vecs[i].f, vecs[i].name);
      chk($sformatf("%s.tgt_c", vecs[i].name),  int'(bus.target_idx),  vecs[i].tgt);
      chk($sformatf("%s.img_c", vecs[i].name),  int'(bus.img_idx),     vecs[i].img);
      chk($sformatf("%s.pend_c", vecs[i].name), int'(bus.pending),     vecs[i].pend);
      chk($sformatf("%s.chg_c", vecs[i].name),  int'(bus.idx_changed), vecs[i].chg);
      chk($sformatf("%s.mode_c", vecs[i].name), int'(bus.mode),        vecs[i].mode);
    end

    // Slideshow: advances every SLIDE_TICKS clocks, 0,1,2,0
    drive(0, 0, 1, 0, "enter_run");
    chk("run.mode", int'(bus.mode), 1);
    for (int k = 1; k <= 30; k++) begin
      drive(0, 0, 0, (k % 5) == 0, "run");
      if (k == 9 || k == 10 || k == 20 || k == 30)
        chk($sformatf("run.tgt_k%0d", k), int'(bus.target_idx), (k / 10) % 3);
    end
    drive(0, 0, 1, 0, "enter_hold");
    chk("hold.mode", int'(bus.mode), 2);
    for (int k = 1; k <= 50; k++) drive(0, 0, 0, (k % 5) == 0, "hold");
    chk("hold.tgt", int'(bus.target_idx), 0);
    drive(0, 0, 1, 0, "back_manual");
    chk("manual.mode", int'(bus.mode), 0);

    // Manual next at terminal count replaces the tick and restarts the timer
    drive(0, 0, 1, 0, "enter_run2");
    for (int k = 1; k <= 9; k++) drive(0, 0, 0, 0, "run2");
    chk("run2.tgt_k9", int'(bus.target_idx), 0);
    drive(1, 0, 0, 0, "run2_next");
    chk("run2.tgt_k10", int'(bus.target_idx), 1);
    for (int k = 11; k <= 19; k++) drive(0, 0, 0, 0, "run2");
    chk("run2.tgt_k19", int'(bus.target_idx), 1);
    drive(0, 0, 0, 0, "run2_tick");
    chk("run2.tgt_k20", int'(bus.target_idx), 2);
    chk("run2.pending", int'(bus.pending), 1);

    // Asynchronous reset mid-AUTO_RUN with a pending request
    #3;
    clr = 1'b0;
    #1;
    model_reset();
    chk("clr.target",  int'(bus.target_idx),  0);
    chk("clr.img",     int'(bus.img_idx),     0);
    chk("clr.pending", int'(bus.pending),     0);
    chk("clr.changed", int'(bus.idx_changed), 0);
    chk("clr.mode",    int'(bus.mode),        0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, (k % 5) == 0, "post_clr");
      chk("post_clr.chg_c", int'(bus.idx_changed), 0);
    end

    // Randomized pulses against the model
    for (int k = 0; k < 800; k++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/img_sel_ctrl.md
Name: img_sel_ctrl

Overview:
Downstream consumer of the debounced button pulses. It converts single-cycle next/prev/mode flags into a displayed image index. The index wraps, supports an automatic slideshow timer, and commits only on a frame boundary so the pixel path never switches images mid-frame. The committed index feeds the image ROM address base in the display pipeline.

Parameters:
NUM_IMG, 4, number of stored images; 2..2^IDX_W, need not be a power of two
IDX_W, 2, width of image index
SLIDE_TICKS, 50_000_000, clk cycles between automatic advances in AUTO_RUN (1 s at 50 MHz)
CNT_W, 26, slideshow counter width; must hold SLIDE_TICKS-1

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-low reset
btn_next  in  1  one-cycle pulse from the debounce stage: step forward
btn_prev  in  1  one-cycle pulse from the debounce stage: step backward
btn_mode  in  1  one-cycle pulse from the debounce stage: cycle mode
frame_start  in  1  one-cycle pulse at start of vertical blanking from the VGA timing block
img_idx  out  IDX_W  committed image index used by the display path
target_idx  out  IDX_W  requested index, not yet committed
pending  out  1  1 while target_idx != img_idx
idx_changed  out  1  one-cycle pulse the cycle after img_idx changes
mode  out  2  00 MANUAL, 01 AUTO_RUN, 10 AUTO_HOLD

Behaviour:
- Reset (clr=0, async): img_idx=0, target_idx=0, pending=0, idx_changed=0, mode=MANUAL, slide counter=0. Reset mid-operation discards any pending request.
- All outputs are registered. Inputs are sampled on posedge clk.
- Step arithmetic on target_idx:
  - next: target_idx==NUM_IMG-1 wraps to 0, else +1.
  - prev: target_idx==0 wraps to NUM_IMG-1, else -1.
  - No modulo on non-power-of-two values; use explicit compare.
- btn_next and btn_prev in the same cycle: no step. Both are ignored.
- Multiple steps before a frame_start accumulate on target_idx. Only the final value is committed.
- Mode FSM, advanced by btn_mode: MANUAL -> AUTO_RUN -> AUTO_HOLD -> MANUAL. Code 11 is unreachable and recovers to MANUAL on the next clock.
- btn_mode together with next/prev in the same cycle: both take effect. The step applies and mode advances.
- Slide counter:
  - Counts only in AUTO_RUN, from 0 to SLIDE_TICKS-1.
  - At SLIDE_TICKS-1 it generates an auto-advance (same as next) and wraps to 0.
  - Cleared to 0 in any other state, and on the cycle of entry into AUTO_RUN.
  - Any manual next/prev accepted in AUTO_RUN clears the counter to 0 that cycle. That step replaces the auto-advance if they coincide: exactly one +1 for next, exactly one -1 for prev.
- AUTO_HOLD: no auto-advance. Manual next/prev still step.
- Commit:
  - On frame_start, img_idx <= current registered target_idx, i.e. the value before any same-cycle step.
  - A step arriving in the same cycle as frame_start is committed at the following frame_start.
  - idx_changed pulses for exactly one cycle, in the cycle after the commit, only if the value differs.
- pending = (target_idx != img_idx), registered. It goes to 0 the cycle after a commit that equalises them.
- Stepping back to the already-committed value before frame_start clears pending. The next frame_start then produces no idx_changed.

Test Plan:
1. Bench uses NUM_IMG=3, SLIDE_TICKS=10. Reset, then btn_next x2, then frame_start -> target_idx=2 and pending=1 before the frame; img_idx=2 and one idx_changed pulse after.
2. From idx 0: btn_prev, frame_start -> img_idx=2 (wrap down). Then btn_next, frame_start -> img_idx=0 (wrap up). Also force btn_next and btn_prev in the same cycle -> no change.
3. btn_mode once (AUTO_RUN), hold with periodic frame_start -> target_idx advances every 10 clk: 0,1,2,0. btn_mode again (AUTO_HOLD) -> no further advance for 50 clk. btn_mode once more -> mode=00.
4. In AUTO_RUN, btn_next at counter=9 -> single +1 only, and the counter restarts, so the next auto step comes 10 clk later.
5. btn_next in the same cycle as frame_start -> img_idx unchanged that frame and pending=1. The next frame_start commits the value.
6. Assert clr mid-AUTO_RUN with pending=1 -> all outputs return to reset values immediately. After release, no idx_changed occurs until a new step is committed.
